// File: rtl/hvsync_if.sv
// Raster timing bundle driven by hvsync_gen.
//   hsync      : horizontal sync (polarity set by the generator build)
//   vsync      : vertical sync (polarity set by the generator build)
//   display_on : beam inside the visible area
//   hpos/vpos  : current beam position
// master = generator side (drives everything), slave = renderer side.
interface hvsync_if;
  logic       hsync;
  logic       vsync;
  logic       display_on;
  logic [8:0] hpos;
  logic [8:0] vpos;

  modport master (
    output hsync,
    output vsync,
    output display_on,
    output hpos,
    output vpos
  );

  modport slave (
    input hsync,
    input vsync,
    input display_on,
    input hpos,
    input vpos
  );
endinterface

// File: rtl/hvsync_gen.sv
// Free-running raster timing generator: horizontal/vertical beam counters with registered
// hsync/vsync and a combinational display-enable.
//
// Ports:
//   clk   : pixel clock, all state on its rising edge
//   reset : synchronous, active-high; returns both counters to 0 and clears the sync registers
//   vid   : hvsync_if.master -- hsync, vsync, display_on, hpos[8:0], vpos[8:0]
//
// Build option:
//   HVSYNC_SYNC_INVERT_EN -- when defined, hsync/vsync are active-low (reset value 1);
//                            otherwise active-high (reset value 0). Counters and
//                            display_on are unaffected.
module hvsync_gen #(
  parameter int unsigned H_DISPLAY = 256,
  parameter int unsigned H_BACK    = 23,
  parameter int unsigned H_FRONT   = 7,
  parameter int unsigned H_SYNC    = 23,
  parameter int unsigned V_DISPLAY = 240,
  parameter int unsigned V_TOP     = 5,
  parameter int unsigned V_BOTTOM  = 14,
  parameter int unsigned V_SYNC    = 3
) (
  input  logic     clk,
  input  logic     reset,
  hvsync_if.master vid
);

  localparam int unsigned HSyncStart = H_DISPLAY + H_FRONT;
  localparam int unsigned HSyncEnd   = HSyncStart + H_SYNC - 1;
  localparam int unsigned HMax       = H_DISPLAY + H_BACK + H_FRONT + H_SYNC - 1;
  localparam int unsigned VSyncStart = V_DISPLAY + V_BOTTOM;
  localparam int unsigned VSyncEnd   = VSyncStart + V_SYNC - 1;
  localparam int unsigned VMax       = V_DISPLAY + V_TOP + V_BOTTOM + V_SYNC - 1;

  localparam logic [8:0] HDisplayW   = 9'(H_DISPLAY);
  localparam logic [8:0] HSyncStartW = 9'(HSyncStart);
  localparam logic [8:0] HSyncEndW   = 9'(HSyncEnd);
  localparam logic [8:0] HMaxW       = 9'(HMax);
  localparam logic [8:0] VDisplayW   = 9'(V_DISPLAY);
  localparam logic [8:0] VSyncStartW = 9'(VSyncStart);
  localparam logic [8:0] VSyncEndW   = 9'(VSyncEnd);
  localparam logic [8:0] VMaxW       = 9'(VMax);

  logic [8:0] hpos_q, hpos_d;
  logic [8:0] vpos_q, vpos_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       hmaxxed, vmaxxed;

  always_comb begin
    // Folding reset into the wrap flags sends both counters to 0 on a reset edge.
    hmaxxed = (hpos_q == HMaxW) | reset;
    vmaxxed = (vpos_q == VMaxW) | reset;

    hpos_d = hmaxxed ? 9'd0 : hpos_q + 9'd1;

    vpos_d = vpos_q;
    if (hmaxxed) begin
      vpos_d = vmaxxed ? 9'd0 : vpos_q + 9'd1;
    end

    // Sync windows are decoded from the pre-edge position, giving one clock of latency.
    hsync_d = 1'b0;
    vsync_d = 1'b0;
    if (!reset) begin
      hsync_d = (hpos_q >= HSyncStartW) && (hpos_q <= HSyncEndW);
      vsync_d = (vpos_q >= VSyncStartW) && (vpos_q <= VSyncEndW);
    end
  end

  always_ff @(posedge clk) begin
    hpos_q  <= hpos_d;
    vpos_q  <= vpos_d;
    hsync_q <= hsync_d;
    vsync_q <= vsync_d;
  end

  assign vid.hpos       = hpos_q;
  assign vid.vpos       = vpos_q;
  assign vid.display_on = (hpos_q < HDisplayW) && (vpos_q < VDisplayW);

`ifdef HVSYNC_SYNC_INVERT_EN
  assign vid.hsync = ~hsync_q;
  assign vid.vsync = ~vsync_q;
`else
  assign vid.hsync = hsync_q;
  assign vid.vsync = vsync_q;
`endif

endmodule

// File: tb/tb_hvsync_gen.sv
module tb_hvsync_gen;

  localparam int HTotal   = 309;
  localparam int VTotal   = 262;
  localparam int FrameLen = HTotal * VTotal;  // 80958

`ifdef HVSYNC_SYNC_INVERT_EN
  localparam bit Inv = 1'b1;
`else
  localparam bit Inv = 1'b0;
`endif

  typedef struct {
    int         t;
    int         tag;  // 0: main run, 1: after mid-frame reset, 2: reset hold
    logic [8:0] hp;
    logic [8:0] vp;
    logic       hs;   // active-level value, polarity applied at compare
    logic       vs;
    logic       de;
  } exp_t;

  logic clk;
  logic reset;
  hvsync_if vid ();

  hvsync_gen dut (
    .clk   (clk),
    .reset (reset),
    .vid   (vid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   hs_line_cnt = 0;
  int   vs_frame_cnt = 0;

  task automatic check(input string name, input int t, input logic [31:0] act,
                       input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s t=%0d: got %0d expected %0d", name, t, act, expv);
    end
  endtask

  // Expected raster state t clocks after the counters were last at (0,0).
  task automatic push_exp(input int t, input int tag);
    exp_t e;
    int   hp;
    int   vp;
    hp = t % HTotal;
    vp = (t / HTotal) % VTotal;
    e.t   = t;
    e.tag = tag;
    e.hp  = 9'(hp);
    e.vp  = 9'(vp);
    e.hs  = (hp >= 264) && (hp <= 286);
    e.vs  = (vp == 254 && hp >= 1) || vp == 255 || vp == 256 || (vp == 257 && hp == 0);
    e.de  = (hp < 256) && (vp < 240);
    exp_q.push_back(e);
  endtask

  // Monitor: one raster sample per clock, checked mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic hs_act;
      logic vs_act;
      e = exp_q.pop_front();
      hs_act = vid.hsync ^ Inv;
      vs_act = vid.vsync ^ Inv;
      check("hpos", e.t, 32'(vid.hpos), 32'(e.hp));
      check("vpos", e.t, 32'(vid.vpos), 32'(e.vp));
      check("hsync", e.t, 32'(vid.hsync), 32'(e.hs ^ Inv));
      check("vsync", e.t, 32'(vid.vsync), 32'(e.vs ^ Inv));
      check("display_on", e.t, 32'(vid.display_on), 32'(e.de));
      if (e.tag == 0 && e.t >= 1 && e.t <= HTotal && hs_act === 1'b1) hs_line_cnt++;
      if (e.tag == 0 && e.t >= 1 && e.t <= FrameLen && vs_act === 1'b1) vs_frame_cnt++;
    end
  end

  initial begin
    int t_end;
    reset = 1'b1;
    // Three reset edges; state sits at (0,0) with syncs idle throughout.
    repeat (3) begin
      @(posedge clk);
      push_exp(0, 2);
    end
    #1 reset = 1'b0;

    // One full frame plus a little, ending at (vpos=2, hpos=150).
    t_end = FrameLen + 2 * HTotal + 150;
    for (int t = 1; t <= t_end; t++) begin
      @(posedge clk);
      push_exp(t, 0);
    end

    // Single-clock reset mid-frame: next edge returns to (0,0), syncs idle.
    #1 reset = 1'b1;
    @(posedge clk);
    push_exp(0, 1);
    #1 reset = 1'b0;
    for (int t = 1; t <= 400; t++) begin
      @(posedge clk);
      push_exp(t, 1);
    end

    repeat (2) @(negedge clk);
    check("queue_drain", -1, 32'(exp_q.size()), 32'd0);
    check("hsync_line_width", -1, 32'(hs_line_cnt), 32'd23);
    check("vsync_frame_width", -1, 32'(vs_frame_cnt), 32'(3 * HTotal));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
